// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, flag bit positions
// and FSM state encodings. The optional divider is enabled with the
// SEQ_ALU_DIV_EN macro; this package is identical in both builds.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t OP_ADD   = 4'b0000;
    localparam alu_op_t OP_SUB   = 4'b0001;
    localparam alu_op_t OP_AND   = 4'b0010;
    localparam alu_op_t OP_ORR   = 4'b0011;
    localparam alu_op_t OP_EOR   = 4'b0100;
    localparam alu_op_t OP_MOV   = 4'b0101;
    localparam alu_op_t OP_MUL   = 4'b0110;
    localparam alu_op_t OP_UMULH = 4'b0111;
    localparam alu_op_t OP_UDIV  = 4'b1000;
    localparam alu_op_t OP_UREM  = 4'b1001;

    // Flag vector packing is {N,Z,C,V}.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Flags reported for an unrecognised op code: only Z is set.
    localparam logic [3:0] FLAGS_UNDEF = 4'b0100;

    // ST_EXEC is a reserved encoding: single-cycle ops are evaluated in the
    // accept cycle and load the result register directly on the way to DONE.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_MUL  = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // True for the op codes handled by the iterative multiplier.
    function automatic logic is_mul_op(alu_op_t op);
        return (op == OP_MUL) || (op == OP_UMULH);
    endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative datapath shared by multiply and divide. One bit is processed
// per cycle for WIDTH cycles after a start pulse; done pulses in the cycle
// of the final iteration, with result showing the post-iteration value.
// A 2*WIDTH accumulator holds {high, low}: for MUL the running product,
// for division {remainder, quotient}. Divider logic is only built when
// SEQ_ALU_DIV_EN is defined.
module seq_muldiv_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
`ifdef SEQ_ALU_DIV_EN
    input  logic             is_div,
`endif
    input  logic             sel_hi,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               sel_hi_q, sel_hi_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

`ifdef SEQ_ALU_DIV_EN
    logic               is_div_q, is_div_d;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;
`endif

    // One shift-add step: add the multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

`ifdef SEQ_ALU_DIV_EN
    // One restoring-division step: shift the next dividend bit into the
    // remainder, trial-subtract the divisor, keep the difference if it did
    // not go negative, and shift the quotient bit into the low half.
    always_comb begin
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!div_diff[WIDTH]) begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end
`endif

    // Next-state for the accumulator, operand, counter and control bits.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        sel_hi_d = sel_hi_q;
`ifdef SEQ_ALU_DIV_EN
        is_div_d = is_div_q;
`endif
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = CNT_W'(WIDTH - 1);
            sel_hi_d = sel_hi;
            acc_d    = {{WIDTH{1'b0}}, b};
            opnd_d   = a;
`ifdef SEQ_ALU_DIV_EN
            is_div_d = is_div;
            if (is_div) begin
                acc_d  = {{WIDTH{1'b0}}, a};
                opnd_d = b;
            end
`endif
        end else if (busy_q) begin
            acc_d = mul_next;
`ifdef SEQ_ALU_DIV_EN
            if (is_div_q) begin
                acc_d = div_next;
            end
`endif
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Datapath and control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples its _d value from before this clock edge.
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            sel_hi_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            sel_hi_q <= sel_hi_d;
        end
    end

`ifdef SEQ_ALU_DIV_EN
    // Remembers whether the current run is a division.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_div_q <= 1'b0;
        end else begin
            is_div_q <= is_div_d;
        end
    end
`endif

    assign busy   = busy_q;
    assign done   = busy_q && (cnt_q == '0);
    assign result = sel_hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes on both sides. Single-cycle
// ops are evaluated in the accept cycle; MUL/UMULH (and UDIV/UREM when
// SEQ_ALU_DIV_EN is defined) run on seq_muldiv_unit for WIDTH cycles.
// The result and {N,Z,C,V} flags are held in DONE until out_ready.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_flags
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] b_add;
    logic [WIDTH:0]   sum;
    logic             add_v;
    logic [WIDTH-1:0] sc_result;
    logic [3:0]       sc_flags;

    logic             mdu_start;
    logic             mdu_sel_hi;
    logic             mdu_busy;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_result;
`ifdef SEQ_ALU_DIV_EN
    logic             mdu_is_div;
    logic [WIDTH-1:0] div0_result;
`endif

    function automatic logic [3:0] pack_flags(logic [WIDTH-1:0] r, logic c, logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    // Adder shared by ADD and SUB; SUB is a + ~b + 1.
    always_comb begin
        b_add = (alu_op == OP_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_add} + (WIDTH + 1)'(alu_op == OP_SUB);
        add_v = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ alu_op[0]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
    end

    // Single-cycle results; anything unrecognised yields zero with Z set.
    always_comb begin
        sc_result = '0;
        sc_flags  = FLAGS_UNDEF;
        case (alu_op)
            OP_ADD, OP_SUB: begin
                sc_result = sum[WIDTH-1:0];
                sc_flags  = pack_flags(sum[WIDTH-1:0], sum[WIDTH], add_v);
            end
            OP_AND: begin
                sc_result = a & b;
                sc_flags  = pack_flags(a & b, 1'b0, 1'b0);
            end
            OP_ORR: begin
                sc_result = a | b;
                sc_flags  = pack_flags(a | b, 1'b0, 1'b0);
            end
            OP_EOR: begin
                sc_result = a ^ b;
                sc_flags  = pack_flags(a ^ b, 1'b0, 1'b0);
            end
            OP_MOV: begin
                sc_result = b;
                sc_flags  = pack_flags(b, 1'b0, 1'b0);
            end
            default: begin
                sc_result = '0;
                sc_flags  = FLAGS_UNDEF;
            end
        endcase
    end

    assign mdu_sel_hi = (alu_op == OP_UMULH) || (alu_op == OP_UREM);
`ifdef SEQ_ALU_DIV_EN
    assign mdu_is_div  = (alu_op == OP_UDIV) || (alu_op == OP_UREM);
    assign div0_result = (alu_op == OP_UDIV) ? '1 : a;
`endif

    // FSM next-state, result/flag loading and multiplier/divider start.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        mdu_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mul_op(alu_op)) begin
                        mdu_start = 1'b1;
                        state_d   = ST_MUL;
`ifdef SEQ_ALU_DIV_EN
                    end else if (mdu_is_div) begin
                        // A zero divisor never starts the unit; its result is
                        // loaded now and DIV falls straight through to DONE.
                        state_d = ST_DIV;
                        if (b == '0) begin
                            result_d = div0_result;
                            flags_d  = pack_flags(div0_result, 1'b0, 1'b1);
                        end else begin
                            mdu_start = 1'b1;
                        end
`endif
                    end else begin
                        result_d = sc_result;
                        flags_d  = sc_flags;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (!mdu_busy) begin
                    state_d = ST_DONE;
                end else if (mdu_done) begin
                    result_d = mdu_result;
                    flags_d  = pack_flags(mdu_result, 1'b0, 1'b0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, result and flag registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    seq_muldiv_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mdu_start),
`ifdef SEQ_ALU_DIV_EN
        .is_div  (mdu_is_div),
`endif
        .sel_hi  (mdu_sel_hi),
        .a       (a),
        .b       (b),
        .busy    (mdu_busy),
        .done    (mdu_done),
        .result  (mdu_result)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign alu_flags = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32). Expected results come from an
// arithmetic reference model; divide expectations follow SEQ_ALU_DIV_EN.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   alu_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [3:0]   alu_flags;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .alu_flags (alu_flags)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: result, {N,Z,C,V} and cycles from accept to out_valid.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] res, output logic [3:0] fl, output int lat);
        logic [2*W-1:0] prod;
        logic [W:0]     s;
        logic           c;
        logic           v;
        prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        c    = 1'b0;
        v    = 1'b0;
        lat  = 1;
        res  = '0;
        case (op)
            4'd0: begin
                s   = {1'b0, x} + {1'b0, y};
                res = s[W-1:0];
                c   = s[W];
                v   = (x[W-1] == y[W-1]) && (res[W-1] != x[W-1]);
            end
            4'd1: begin
                res = x - y;
                c   = (x >= y);
                v   = (x[W-1] != y[W-1]) && (res[W-1] != x[W-1]);
            end
            4'd2: res = x & y;
            4'd3: res = x | y;
            4'd4: res = x ^ y;
            4'd5: res = y;
            4'd6: begin res = prod[W-1:0];   lat = W + 1; end
            4'd7: begin res = prod[2*W-1:W]; lat = W + 1; end
`ifdef SEQ_ALU_DIV_EN
            4'd8: begin
                if (y == '0) begin res = '1; v = 1'b1; lat = 2; end
                else begin res = x / y; lat = W + 1; end
            end
            4'd9: begin
                if (y == '0) begin res = x; v = 1'b1; lat = 2; end
                else begin res = x % y; lat = W + 1; end
            end
`endif
            default: begin
                res = '0;
                fl  = 4'b0100;
                return;
            end
        endcase
        fl = {res[W-1], res == '0, c, v};
    endfunction

    // Issue one op, check latency, busy behaviour, result, flags, then
    // hold off the consumer for 'stall' cycles before completing.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int stall);
        logic [W-1:0] exp_res;
        logic [3:0]   exp_fl;
        int           exp_lat;
        int           n;
        int           lat;
        logic         ready_seen;
        model(op, x, y, exp_res, exp_fl, exp_lat);
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check({tag, " in_ready before accept"}, W'(in_ready), W'(1));
        in_valid = 1'b1;
        alu_op   = op;
        a        = x;
        b        = y;
        step();
        // Garbage while busy must be ignored and must not disturb the op.
        alu_op     = 4'($urandom);
        a          = $urandom;
        b          = $urandom;
        lat        = 1;
        ready_seen = 1'b0;
        while (!out_valid && lat < W + 10) begin
            if (in_ready) ready_seen = 1'b1;
            step();
            lat++;
        end
        check({tag, " latency"}, W'(lat), W'(exp_lat));
        check({tag, " in_ready low while busy"}, W'(ready_seen), W'(0));
        check({tag, " result"}, result, exp_res);
        check({tag, " flags"}, W'(alu_flags), W'(exp_fl));
        for (int i = 0; i < stall; i++) begin
            step();
            check({tag, " held out_valid"}, W'(out_valid), W'(1));
            check({tag, " held in_ready"}, W'(in_ready), W'(0));
            check({tag, " held result"}, result, exp_res);
            check({tag, " held flags"}, W'(alu_flags), W'(exp_fl));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, W'(out_valid), W'(0));
        check({tag, " in_ready after handshake"}, W'(in_ready), W'(1));
    endtask

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (2) step();
        check("reset out_valid", W'(out_valid), W'(0));
        check("reset in_ready", W'(in_ready), W'(1));
        check("reset result", result, '0);
        check("reset flags", W'(alu_flags), W'(0));
        reset_n = 1'b1;
        step();

        do_op("ADD overflow", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        do_op("SUB equal", 4'd1, 32'd5, 32'd5, 0);
        do_op("SUB borrow", 4'd1, 32'd3, 32'd9, 1);
        do_op("EOR", 4'd4, 32'hFF00_FF00, 32'hFFFF_0000, 0);
        do_op("AND", 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        do_op("ORR", 4'd3, 32'h8000_0000, 32'h0000_0001, 0);
        do_op("MUL", 4'd6, 32'hFFFF_FFFF, 32'd2, 0);
        do_op("UMULH", 4'd7, 32'hFFFF_FFFF, 32'd2, 0);
        do_op("MOV backpressure", 4'd5, 32'h1234_5678, 32'd0, 5);
        do_op("UDIV", 4'd8, 32'd100, 32'd7, 0);
        do_op("UREM", 4'd9, 32'd100, 32'd7, 0);
        do_op("UDIV by zero", 4'd8, 32'd9, 32'd0, 0);
        do_op("UREM by zero", 4'd9, 32'h8000_0003, 32'd0, 0);
        do_op("undefined op", 4'd13, 32'hDEAD_BEEF, 32'h1, 0);

        // Reset in the middle of a multiply.
        in_valid = 1'b1;
        alu_op   = 4'd6;
        a        = 32'h1234_5678;
        b        = 32'h9ABC_DEF0;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        reset_n = 1'b0;
        #2;
        check("mid-MUL reset out_valid", W'(out_valid), W'(0));
        check("mid-MUL reset in_ready", W'(in_ready), W'(1));
        step();
        reset_n = 1'b1;
        step();
        check("after reset out_valid", W'(out_valid), W'(0));
        check("after reset in_ready", W'(in_ready), W'(1));
        do_op("ADD after reset", 4'd0, 32'd2, 32'd3, 0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 24; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
            if ((rop == 4'd8 || rop == 4'd9) && $urandom_range(0, 1) == 1) begin
                rb = W'($urandom_range(1, 1000));
            end
            do_op("random", rop, ra, rb, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
